// File: rtl/flag_branch_unit_if.sv
// Bundle of flag-write, branch-decode and redirect signals between the pipeline
// and the flag/branch unit. clk and reset travel as plain ports.
interface flag_branch_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
);
  logic                  ex_set_flags;
  logic [3:0]            ex_flags;
  logic                  id_valid;
  logic [1:0]            id_br_type;
  logic [3:0]            id_cond;
  logic [DATA_WIDTH-1:0] id_reg_data;
  logic [3:0]            flags_q;
  logic                  redirect;
  logic                  flush_id;
  logic [CNT_WIDTH-1:0]  taken_count;

  modport master (
    output ex_set_flags, ex_flags, id_valid, id_br_type, id_cond, id_reg_data,
    input  flags_q, redirect, flush_id, taken_count
  );

  modport slave (
    input  ex_set_flags, ex_flags, id_valid, id_br_type, id_cond, id_reg_data,
    output flags_q, redirect, flush_id, taken_count
  );
endinterface

// File: rtl/flag_branch_unit.sv
// NZCV flag register with EX->ID forwarding, ID-stage resolution of B/CBZ/B.cond,
// registered redirect/flush pulse with one-cycle wrong-path squash, taken counter.
module flag_branch_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              reset,
  flag_branch_unit_if.slave bus
);

  typedef enum logic [0:0] {NORMAL = 1'b0, SQUASH = 1'b1} state_t;

  localparam logic [1:0] BR_B    = 2'b01;
  localparam logic [1:0] BR_CBZ  = 2'b10;
  localparam logic [1:0] BR_COND = 2'b11;

  state_t               state_q, state_d;
  logic [3:0]           flags_q, flags_d;
  logic                 redirect_q, redirect_d;
  logic                 flush_q, flush_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [3:0] eff_flags_s;
  logic       cbz_hit_s;
  logic       cond_true_s;
  logic       take_s;

  // Odd codes invert the even base condition; codes E and F are always true.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (cond[3:1] == 3'd7) begin
      return 1'b1;
    end else begin
      return cond[0] ? ~base : base;
    end
  endfunction

  // Branch resolution and next-state logic.
  always_comb begin
    eff_flags_s = bus.ex_set_flags ? bus.ex_flags : flags_q;
    cbz_hit_s   = (bus.id_reg_data == {DATA_WIDTH{1'b0}});
    cond_true_s = cond_eval(bus.id_cond, eff_flags_s);
    take_s      = 1'b0;
    state_d     = state_q;
    flags_d     = flags_q;
    redirect_d  = 1'b0;
    flush_d     = 1'b0;
    count_d     = count_q;

    if (bus.ex_set_flags) begin
      flags_d = bus.ex_flags;
    end else begin
      flags_d = flags_q;
    end

    case (state_q)
      NORMAL: begin
        if (bus.id_valid) begin
          case (bus.id_br_type)
            BR_B:    take_s = 1'b1;
            BR_CBZ:  take_s = cbz_hit_s;
            BR_COND: take_s = cond_true_s;
            default: take_s = 1'b0;
          endcase
        end else begin
          take_s = 1'b0;
        end
        if (take_s) begin
          state_d    = SQUASH;
          redirect_d = 1'b1;
          flush_d    = 1'b1;
          count_d    = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          state_d = NORMAL;
        end
      end
      SQUASH:  state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NORMAL;
      flags_q    <= 4'b0000;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      count_q    <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      count_q    <= count_d;
    end
  end

  assign bus.flags_q     = flags_q;
  assign bus.redirect    = redirect_q;
  assign bus.flush_id    = flush_q;
  assign bus.taken_count = count_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: vector table for single decisions plus
// hand-written reset, squash, wrap and reset-vs-take sequences.
module tb_flag_branch_unit;
  localparam int DW = 64;
  // Narrow counter keeps the wrap sequence short.
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [CW-1:0] cnt_exp;

  flag_branch_unit_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  flag_branch_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pre;
    logic        set;
    logic [3:0]  exf;
    logic        valid;
    logic [1:0]  br;
    logic [3:0]  cond;
    logic [63:0] data;
    logic        exp_take;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic set, input logic [3:0] exf, input logic valid,
                       input logic [1:0] br, input logic [3:0] cond, input logic [63:0] data);
    bus.ex_set_flags = set;
    bus.ex_flags     = exf;
    bus.id_valid     = valid;
    bus.id_br_type   = br;
    bus.id_cond      = cond;
    bus.id_reg_data  = data;
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 1'b0, 2'b00, 4'h0, 64'h1);
  endtask

  initial begin
    //          pre      set   exf      vld   br     cond  data                   take  flags
    vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'b10, 4'h0, 64'h0,                 1'b1, 4'b0000};
    vecs[1]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'b10, 4'h0, 64'h8000000000000000, 1'b0, 4'b0000};
    vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'b10, 4'h0, 64'd1,                 1'b0, 4'b0000};
    vecs[3]  = '{4'b0000, 1'b1, 4'b0100, 1'b1, 2'b11, 4'h0, 64'h5,                 1'b1, 4'b0100};
    vecs[4]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'b11, 4'h1, 64'h5,                 1'b0, 4'b0100};
    vecs[5]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'b11, 4'hA, 64'h5,                 1'b1, 4'b1001};
    vecs[6]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'b11, 4'hB, 64'h5,                 1'b0, 4'b1001};
    vecs[7]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'b11, 4'hB, 64'h5,                 1'b1, 4'b1000};
    vecs[8]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'b11, 4'hC, 64'h5,                 1'b0, 4'b1000};
    vecs[9]  = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'b11, 4'h8, 64'h5,                 1'b0, 4'b0110};
    vecs[10] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'b11, 4'h9, 64'h5,                 1'b1, 4'b0110};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'b01, 4'h0, 64'h0,                 1'b0, 4'b0000};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'b00, 4'hE, 64'h0,                 1'b0, 4'b0000};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'b11, 4'hE, 64'h5,                 1'b1, 4'b0000};
    vecs[14] = '{4'b0000, 1'b1, 4'b0010, 1'b1, 2'b11, 4'h2, 64'h5,                 1'b1, 4'b0010};
    vecs[15] = '{4'b0010, 1'b1, 4'b0000, 1'b1, 2'b11, 4'h2, 64'h5,                 1'b0, 4'b0000};

    // Reset with random inputs for two cycles.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
            {$urandom, $urandom});
      tick();
    end
    chk("reset_flags", 64'(bus.flags_q), 64'h0);
    chk("reset_redirect", 64'(bus.redirect), 64'h0);
    chk("reset_flush", 64'(bus.flush_id), 64'h0);
    chk("reset_count", 64'(bus.taken_count), 64'h0);
    reset = 1'b0;
    idle();
    tick();
    cnt_exp = '0;

    // Table: preload flags, present the vector, check the pulse, then drain.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].pre, 1'b0, 2'b00, 4'h0, 64'h1);
      tick();
      drive(vecs[i].set, vecs[i].exf, vecs[i].valid, vecs[i].br, vecs[i].cond, vecs[i].data);
      tick();
      if (vecs[i].exp_take) cnt_exp = cnt_exp + 1'b1;
      chk($sformatf("vec%0d_redirect", i), 64'(bus.redirect), 64'(vecs[i].exp_take));
      chk($sformatf("vec%0d_flush", i), 64'(bus.flush_id), 64'(vecs[i].exp_take));
      chk($sformatf("vec%0d_flags", i), 64'(bus.flags_q), 64'(vecs[i].exp_flags));
      chk($sformatf("vec%0d_count", i), 64'(bus.taken_count), 64'(cnt_exp));
      idle();
      tick();
      chk($sformatf("vec%0d_pulse_end", i), 64'(bus.redirect), 64'h0);
    end

    // Back-to-back B: the second is wrong-path, the third resolves normally.
    drive(1'b0, 4'b0000, 1'b1, 2'b01, 4'h0, 64'h1);
    tick();
    cnt_exp = cnt_exp + 1'b1;
    chk("sq_t1_redirect", 64'(bus.redirect), 64'h1);
    chk("sq_t1_count", 64'(bus.taken_count), 64'(cnt_exp));
    tick();
    chk("sq_t2_redirect", 64'(bus.redirect), 64'h0);
    chk("sq_t2_flush", 64'(bus.flush_id), 64'h0);
    chk("sq_t2_count", 64'(bus.taken_count), 64'(cnt_exp));
    tick();
    cnt_exp = cnt_exp + 1'b1;
    chk("sq_t3_redirect", 64'(bus.redirect), 64'h1);
    chk("sq_t3_count", 64'(bus.taken_count), 64'(cnt_exp));
    idle();
    tick();

    // Flag write proceeds while squashing.
    drive(1'b0, 4'b0000, 1'b1, 2'b01, 4'h0, 64'h1);
    tick();
    cnt_exp = cnt_exp + 1'b1;
    drive(1'b1, 4'b1111, 1'b1, 2'b01, 4'h0, 64'h1);
    tick();
    chk("sq_flag_write", 64'(bus.flags_q), 64'hF);
    chk("sq_flag_noredirect", 64'(bus.redirect), 64'h0);
    idle();
    tick();

    // Drive the counter to all-ones, then one more take wraps it.
    for (int i = 0; i < 300 && cnt_exp != {CW{1'b1}}; i++) begin
      drive(1'b0, 4'b0000, 1'b1, 2'b01, 4'h0, 64'h1);
      tick();
      cnt_exp = cnt_exp + 1'b1;
      idle();
      tick();
    end
    chk("wrap_preload", 64'(bus.taken_count), 64'(cnt_exp));
    chk("wrap_at_max", 64'(cnt_exp), 64'hFF);
    drive(1'b0, 4'b0000, 1'b1, 2'b01, 4'h0, 64'h1);
    tick();
    chk("wrap_zero", 64'(bus.taken_count), 64'h0);
    chk("wrap_redirect", 64'(bus.redirect), 64'h1);
    idle();
    tick();

    // Reset coincident with a taken CBZ: reset wins.
    reset = 1'b1;
    drive(1'b0, 4'b0000, 1'b1, 2'b10, 4'h0, 64'h0);
    tick();
    chk("rst_take_redirect", 64'(bus.redirect), 64'h0);
    chk("rst_take_flush", 64'(bus.flush_id), 64'h0);
    chk("rst_take_count", 64'(bus.taken_count), 64'h0);
    reset = 1'b0;
    drive(1'b0, 4'b0000, 1'b1, 2'b01, 4'h0, 64'h1);
    tick();
    chk("post_rst_normal_redirect", 64'(bus.redirect), 64'h1);
    chk("post_rst_normal_count", 64'(bus.taken_count), 64'h1);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer side of the ALU zero/flag path.
- Holds the architectural NZCV flag register, written by flag-setting EX-stage instructions (ADDS/SUBS/ANDS), and resolves B, CBZ and B.cond in the ID stage.
- Registers a one-cycle redirect/flush pulse and squashes the wrong-path instruction that follows a taken branch.
- Keeps a wrapping count of taken branches for performance debug.

Parameters:
- DATA_WIDTH, 64: width of the CBZ operand.
- CNT_WIDTH, 16: width of the taken-branch counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ex_set_flags  input  1  instruction in EX writes flags this cycle.
- ex_flags  input  4  {N,Z,C,V} from the EX ALU; Z is the ALU zero detect.
- id_valid  input  1  ID holds a real instruction.
- id_br_type  input  2  branch type: 00 none, 01 B, 10 CBZ, 11 B.cond.
- id_cond  input  4  LEGv8 condition code for B.cond.
- id_reg_data  input  DATA_WIDTH  forwarded Rt value for CBZ.
- flags_q  output  4  architectural {N,Z,C,V} register.
- redirect  output  1  registered pulse: fetch must load the branch target.
- flush_id  output  1  registered pulse: squash the instruction now in ID.
- taken_count  output  CNT_WIDTH  number of taken branches, wraps.

Behaviour:
- Reset: when reset=1 at a clock edge, flags_q=4'b0000, redirect=0, flush_id=0, taken_count=0, and the FSM goes to NORMAL. Reset has priority over every other event, including an in-flight decision.
- Flag register: if ex_set_flags=1 at an edge, flags_q <= ex_flags; otherwise flags_q holds.
- Flag forwarding: the effective flags are ex_flags when ex_set_flags=1 in the same cycle, else flags_q. The flags in effect for B.cond are always those of the youngest older flag setter.
- CBZ evaluation is combinational: cbz_hit = (id_reg_data == 0) across all DATA_WIDTH bits.
- Condition evaluation uses the effective N, Z, C, V:
  - EQ 0: Z. NE 1: !Z.
  - HS 2: C. LO 3: !C.
  - MI 4: N. PL 5: !N.
  - VS 6: V. VC 7: !V.
  - HI 8: C&!Z. LS 9: !(C&!Z).
  - GE A: N==V. LT B: N!=V.
  - GT C: !Z&(N==V). LE D: !(!Z&(N==V)).
  - E and F: always true.
- Taken decision in cycle T: take = id_valid & (state==NORMAL) & ((id_br_type==01) | (id_br_type==10 & cbz_hit) | (id_br_type==11 & cond_true)). id_br_type==00 never takes.
- Latency: when take=1 in cycle T, redirect=1 and flush_id=1 for exactly cycle T+1, then both return to 0. No combinational path from the inputs to any output.
- FSM:
  - NORMAL -> SQUASH when take=1; otherwise stay in NORMAL.
  - SQUASH -> NORMAL unconditionally after 1 cycle.
  - In SQUASH the ID instruction is wrong-path, so take is forced to 0 even if a taken-looking branch is presented. Back-to-back branches therefore produce at most one redirect per two cycles.
- Flag writes are never blocked by SQUASH, because the EX instruction is older and valid.
- taken_count increments by 1 on each cycle with take=1 and wraps from 2^CNT_WIDTH-1 to 0 with no saturation.
- Simultaneous events:
  - ex_set_flags and B.cond in the same cycle: the decision uses ex_flags, and flags_q updates at the same edge.
  - reset with take=1: reset wins; redirect=0 and the counter is unchanged from 0.
- id_valid=0 means no decision is made, regardless of id_br_type.

Test Plan:
- Reset: hold reset for 2 cycles with random inputs -> flags_q=0, redirect=0, flush_id=0, taken_count=0.
- CBZ: id_valid=1, br=10, data=64'h0 -> redirect=1 and flush_id=1 next cycle, taken_count=1. Then data=64'h8000000000000000 and data=64'd1 (each presented in a NORMAL cycle) -> no redirect.
- Forwarding: flags_q=0000; in one cycle ex_set_flags=1, ex_flags=0100 with B.cond EQ -> taken, flags_q=0100 after the edge. Next NORMAL cycle, B.cond NE with no flag write -> not taken.
- Signed conditions: flags_q=1001 (N=1, V=1) -> GE taken, LT not taken. flags_q=1000 -> LT taken, GT not taken. flags_q=0110 -> HI not taken, LS taken.
- Squash: B (br=01) in cycles T and T+1 -> one redirect at T+1, none at T+2, taken_count increments by 1 only. A branch at T+2 is evaluated normally.
- Wrap and reset: preload taken_count=16'hFFFF through taken branches, take once more -> 16'h0000. Assert reset in the same cycle as a taken CBZ -> no redirect, state NORMAL.
